program_loader: RTL
===================

# program_loader

Receives a program image as a byte stream from the UART receiver and writes it into the instruction memory one 32-bit word at a time through the memory's program-write port (`pro_data`, `pro_addr`, `memwrite`). It holds the core in reset via `loading` until the image is complete. It then returns a one-byte acknowledge to the host through the UART transmitter. It sits between the UART pair and the instruction memory and is active only during boot.

## Interface
- `MAX_WORDS`, 64, instruction memory capacity in words; valid range 1 to 64.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_data`  out  8  acknowledge byte to transmit.
- `tx_start`  out  1  one-cycle transmit request.
- `pro_data`  out  32  instruction word to write.
- `pro_addr`  out  32  program-write byte address.
- `memwrite`  out  1  one-cycle write strobe.
- `loading`  out  1  high while the image is incomplete; the core is held in reset while high.
- `done`  out  1  sticky; the load completed successfully.
- `err`  out  1  sticky; the header word count exceeded `MAX_WORDS`.

## Operation
- Stream format:
  - 4-byte little-endian header giving word count N.
  - Then N words, each 4 bytes little-endian (first byte goes to bits [7:0]).
- States: `HDR` → `DATA` → `ACK` → `DONE`, plus `ACK_ERR` → `ERR`.
- A 2-bit byte counter and a word counter k (7 bits) track progress.
- `HDR`: shift in 4 bytes.
  - On the 4th byte: if N=0, go to `ACK`.
  - If N>`MAX_WORDS`, go to `ACK_ERR`.
  - Otherwise, go to `DATA` with k=0.
  - Only N[31:0] compared; full 32-bit compare, no truncation.
- `DATA`: assemble bytes. On the 4th byte of word k, issue the write (see below) and increment k.
  - After the write for k=N-1, go to `ACK`.
- Addressing: the instruction memory stores a program write at word index `pro_addr[7:2]`−1.
  - The loader therefore drives `pro_addr` = 4·(k+1), so word k lands at index k.
  - `pro_addr[31:8]`=0 always; `pro_addr[1:0]`=0 always.
- `ACK`: wait for `tx_busy`=0, pulse `tx_start` with `tx_data`=8'hAA, then go to `DONE`.
- `ACK_ERR`: same as `ACK` but with `tx_data`=8'hEE, then go to `ERR`.
- `DONE`: `done`=1, `loading`=0. Remain there until reset.
- `ERR`: `err`=1, `loading` stays 1. Remain there until reset.
- `rx_valid` is ignored in `ACK`, `ACK_ERR`, `DONE` and `ERR`. Bytes arriving there are dropped.
- Reset mid-load: everything returns to `HDR` immediately. A partially assembled word is discarded and no `memwrite` is issued.

## Timing
- Reset values:
  - state=`HDR`
  - `loading`=1
  - `done`=0, `err`=0
  - `memwrite`=0, `tx_start`=0
  - `pro_data`=0, `pro_addr`=0, `tx_data`=0
- All outputs are registered.
- Write timing: at the edge sampling the 4th byte of a word (`rx_valid`=1):
  - `pro_data`, `pro_addr` update and `memwrite`←1.
  - At the next edge `memwrite`←0.
  - `pro_data`/`pro_addr` hold until the next write.
- `memwrite` is high for exactly 1 cycle per word and never on two consecutive cycles.
- Back-to-back `rx_valid` on every cycle must be accepted with no loss. Minimum spacing between writes is 4 cycles.
- State transition after the last word: the state becomes `ACK` on the same edge that raises the final `memwrite`.
- `ACK`: `tx_start` rises on the first edge in `ACK` where `tx_busy`=0. It falls at the next edge, on the same edge the state moves to `DONE`.
- `done`/`loading` change on that same edge.
- Latency: last byte strobe → `memwrite` is 1 edge. With `tx_busy`=0, last byte strobe → `tx_start` is 2 edges and → `done` is 3 edges.
- N=0: header complete → `ACK` next cycle. No `memwrite` at all.
- N=`MAX_WORDS`: final `pro_addr` = 4·`MAX_WORDS` (8'h100 truncates to `pro_addr[7:2]`=0 for 64; memory wraps index to 63, as required).

## Test plan
- Header N=2, then bytes 13 01 50 00 / EF 00 80 00, all spaced by 3 idle cycles:
  - two `memwrite` pulses: (`pro_addr`=4, `pro_data`=32'h00500113) and (`pro_addr`=8, `pro_data`=32'h008000EF);
  - then `tx_start` with 8'hAA, `done`=1, `loading`=0.
- Same stream with `rx_valid` high every cycle → identical writes, spaced exactly 4 cycles.
- Header N=0 → no `memwrite`; `tx_data`=8'hAA; `done`=1 within 3 cycles.
- Header N=65 → `tx_data`=8'hEE, `err`=1, `loading`=1. Subsequent bytes produce no `memwrite`.
- `tx_busy` held 1 for 20 cycles in `ACK` → `tx_start` stays 0, then pulses once on the first cycle `tx_busy`=0.
- Assert `rstn`=0 after 2 bytes of word 1 → outputs at reset values immediately. A fresh N=1 stream then writes `pro_addr`=4 correctly.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: UART byte stream to instruction memory words, then one-byte ack
module program_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [31:0] pro_data,
    output logic [31:0] pro_addr,
    output logic        memwrite,
    output logic        loading,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_ACK, S_ACK_ERR, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAX_W = MAX_WORDS;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [6:0]  n_q, n_d;
    logic [6:0]  k_q, k_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic [31:0] pro_data_q, pro_data_d;
    logic [7:0]  pro_addr_q, pro_addr_d;
    logic        memwrite_q, memwrite_d;
    logic        loading_q, loading_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] word;
    logic [6:0]  k_plus1;
    logic        last_byte;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        n_d        = n_q;
        k_d        = k_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pro_data_d = pro_data_q;
        pro_addr_d = pro_addr_q;
        memwrite_d = 1'b0;

        // Bytes land little-endian: the newest byte becomes the top of the word.
        word      = {rx_data, shift_q};
        k_plus1   = k_q + 7'd1;
        last_byte = rx_valid && (byte_cnt_q == 2'd3);

        if (rx_valid && (state_q == S_HDR || state_q == S_DATA)) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = word[31:8];
        end

        case (state_q)
            S_HDR: begin
                if (last_byte) begin
                    if (word == 32'd0) begin
                        state_d = S_ACK;
                    end else if (word > MAX_W) begin
                        state_d = S_ACK_ERR;
                    end else begin
                        state_d = S_DATA;
                        n_d     = word[6:0];
                        k_d     = 7'd0;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    // Memory stores at pro_addr[7:2]-1, so address k+1 puts word k at index k.
                    memwrite_d = 1'b1;
                    pro_data_d = word;
                    pro_addr_d = {k_plus1[5:0], 2'b00};
                    k_d        = k_plus1;
                    if (k_plus1 == n_q) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK, S_ACK_ERR: begin
                if (tx_start_q) begin
                    state_d = (state_q == S_ACK) ? S_DONE : S_ERR;
                end else if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = (state_q == S_ACK) ? 8'hAA : 8'hEE;
                end
            end
            S_DONE, S_ERR: begin
            end
            default: state_d = S_HDR;
        endcase

        loading_d = (state_d != S_DONE);
        done_d    = done_q | (state_d == S_DONE);
        err_d     = err_q | (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_HDR;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            n_q        <= 7'd0;
            k_q        <= 7'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            pro_data_q <= 32'd0;
            pro_addr_q <= 8'd0;
            memwrite_q <= 1'b0;
            loading_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            k_q        <= k_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            pro_data_q <= pro_data_d;
            pro_addr_q <= pro_addr_d;
            memwrite_q <= memwrite_d;
            loading_q  <= loading_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign pro_data = pro_data_q;
    assign pro_addr = {24'd0, pro_addr_q};
    assign memwrite = memwrite_q;
    assign loading  = loading_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
